// File: rtl/ds_pkg.sv
// Shared widths, FSM encoding and rounding helper for the 2x2 box downsampler.
package ds_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int SUM_W  = 10;
  localparam int CNT_W  = 8;

  localparam logic [SUM_W-1:0] RND = SUM_W'(2);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    RD3  = 3'd4,
    ACC  = 3'd5,
    WR   = 3'd6,
    DONE = 3'd7
  } state_t;

  // Sum of four bytes plus 2 never exceeds 1022, so the shifted result fits a byte.
  function automatic logic [DATA_W-1:0] round_avg(input logic [SUM_W-1:0] sum);
    logic [SUM_W-1:0] biased;
    biased = sum + RND;
    return biased[SUM_W-1:2];
  endfunction

endpackage

// File: rtl/dram_addr_gen.sv
// Output-pixel walker: ox/oy counters plus source row/column and destination offsets,
// all formed by adders and stepped once per output pixel.
module dram_addr_gen
  import ds_pkg::*;
#(
  parameter int                IMG_W    = 128,
  parameter int                IMG_H    = 128,
  parameter logic [ADDR_W-1:0] SRC_BASE = 16'h0000,
  parameter logic [ADDR_W-1:0] DST_BASE = 16'h4000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] src_addr,
  output logic [ADDR_W-1:0] dst_addr,
  output logic              last_pixel
);

  localparam int OUT_W = IMG_W / 2;
  localparam int OUT_H = IMG_H / 2;
  localparam logic [CNT_W-1:0]  OX_LAST  = CNT_W'(OUT_W - 1);
  localparam logic [CNT_W-1:0]  OY_LAST  = CNT_W'(OUT_H - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(2 * IMG_W);

  logic [CNT_W-1:0]  ox_reg;
  logic [CNT_W-1:0]  oy_reg;
  logic [ADDR_W-1:0] row_off_reg;
  logic [ADDR_W-1:0] col_off_reg;
  logic [ADDR_W-1:0] dst_off_reg;
  logic              ox_last;
  logic              oy_last;

  assign ox_last    = (ox_reg == OX_LAST);
  assign oy_last    = (oy_reg == OY_LAST);
  assign last_pixel = ox_last && oy_last;
  assign src_addr   = SRC_BASE + col_off_reg;
  assign dst_addr   = DST_BASE + dst_off_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ox_reg      <= '0;
      oy_reg      <= '0;
      row_off_reg <= '0;
      col_off_reg <= '0;
      dst_off_reg <= '0;
    end else if (clear) begin
      ox_reg      <= '0;
      oy_reg      <= '0;
      row_off_reg <= '0;
      col_off_reg <= '0;
      dst_off_reg <= '0;
    end else if (advance) begin
      if (!ox_last) begin
        ox_reg      <= ox_reg + CNT_W'(1);
        col_off_reg <= col_off_reg + ADDR_W'(2);
        dst_off_reg <= dst_off_reg + ADDR_W'(1);
      end else if (!oy_last) begin
        // Column wrap: skip the odd source row that the previous block pair consumed.
        ox_reg      <= '0;
        oy_reg      <= oy_reg + CNT_W'(1);
        row_off_reg <= row_off_reg + ROW_STEP;
        col_off_reg <= row_off_reg + ROW_STEP;
        dst_off_reg <= dst_off_reg + ADDR_W'(1);
      end else begin
        ox_reg      <= '0;
        oy_reg      <= '0;
        row_off_reg <= '0;
        col_off_reg <= '0;
        dst_off_reg <= '0;
      end
    end
  end

endmodule

// File: rtl/dram_box_downsampler.sv
// Frame sequencer: four byte reads per 2x2 block, rounded average, one byte write.
// Every memory-facing output is a register updated alongside the state.
module dram_box_downsampler
  import ds_pkg::*;
#(
  parameter int                IMG_W    = 128,
  parameter int                IMG_H    = 128,
  parameter logic [ADDR_W-1:0] SRC_BASE = 16'h0000,
  parameter logic [ADDR_W-1:0] DST_BASE = 16'h4000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] ROW_OFF  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ROW_OFF1 = ADDR_W'(IMG_W + 1);

  state_t            state_reg;
  logic [SUM_W-1:0]  sum_reg;
  logic              last_reg;
  logic [SUM_W-1:0]  rdata_ext;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic              last_pixel;
  logic              clear;
  logic              advance;

  assign rdata_ext = SUM_W'(mem_rdata);
  assign clear     = (state_reg == IDLE) && start;
  // Stepping while entering WR lets the following RD0 use the next pixel's address.
  assign advance   = (state_reg == ACC);

  dram_addr_gen #(
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .SRC_BASE (SRC_BASE),
    .DST_BASE (DST_BASE)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .advance    (advance),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .last_pixel (last_pixel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_addr  <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_wdata <= '0;
      sum_reg   <= '0;
      last_reg  <= 1'b0;
    end else begin
      done      <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= RD0;
            busy      <= 1'b1;
            mem_read  <= 1'b1;
            mem_addr  <= SRC_BASE;
          end
        end
        RD0: begin
          state_reg <= RD1;
          mem_read  <= 1'b1;
          mem_addr  <= src_addr + ADDR_W'(1);
        end
        // Read data lags its strobe by one cycle, so each state consumes the previous read.
        RD1: begin
          state_reg <= RD2;
          sum_reg   <= rdata_ext;
          mem_read  <= 1'b1;
          mem_addr  <= src_addr + ROW_OFF;
        end
        RD2: begin
          state_reg <= RD3;
          sum_reg   <= sum_reg + rdata_ext;
          mem_read  <= 1'b1;
          mem_addr  <= src_addr + ROW_OFF1;
        end
        RD3: begin
          state_reg <= ACC;
          sum_reg   <= sum_reg + rdata_ext;
        end
        ACC: begin
          state_reg <= WR;
          sum_reg   <= sum_reg + rdata_ext;
          mem_write <= 1'b1;
          mem_addr  <= dst_addr;
          mem_wdata <= round_avg(sum_reg + rdata_ext);
          last_reg  <= last_pixel;
        end
        WR: begin
          if (last_reg) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            state_reg <= RD0;
            mem_read  <= 1'b1;
            mem_addr  <= src_addr;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_box_downsampler.sv
// Bench: a small 8x8 instance for directed and handshake cases, and a default 128x128 instance
// for a full random frame; both checked every cycle against a pixel/phase timing model.
module tb_dram_box_downsampler;

  localparam int IW0 = 8;
  localparam int N0  = (IW0 / 2) * (IW0 / 2);
  localparam int IW1 = 128;
  localparam int N1  = (IW1 / 2) * (IW1 / 2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n0, rst_n1, start0, start1;
  logic        busy_s  [2];
  logic        done_s  [2];
  logic        rd_s    [2];
  logic        wr_s    [2];
  logic [15:0] addr_s  [2];
  logic [7:0]  wdata_s [2];
  logic [7:0]  rdata_s [2];

  logic [7:0] src_img [2][65536];
  logic [7:0] dst_mem [2][65536];

  int errors = 0;
  int checks = 0;

  logic [15:0] rd_q [$];
  logic [15:0] wr_q [$];

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_dut
    localparam int          W  = (gi == 0) ? IW0 : IW1;
    localparam logic [15:0] SB = (gi == 0) ? 16'h0100 : 16'h0000;
    dram_box_downsampler #(
      .IMG_W    (W),
      .IMG_H    (W),
      .SRC_BASE (SB),
      .DST_BASE (16'h4000)
    ) u_dut (
      .clk       (clk),
      .rst_n     ((gi == 0) ? rst_n0 : rst_n1),
      .start     ((gi == 0) ? start0 : start1),
      .busy      (busy_s[gi]),
      .done      (done_s[gi]),
      .mem_addr  (addr_s[gi]),
      .mem_read  (rd_s[gi]),
      .mem_write (wr_s[gi]),
      .mem_wdata (wdata_s[gi]),
      .mem_rdata (rdata_s[gi])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // RAM with registered read; source image and destination bytes kept apart
  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rd_s[k]) rdata_s[k] <= src_img[k][addr_s[k]];
      if (wr_s[k]) dst_mem[k][addr_s[k]] <= wdata_s[k];
    end
  end

  // Reference model: cycle c of a frame is pixel (c-1)/6, phase (c-1)%6
  bit act [2];
  int cyc [2];
  initial forever begin
    int w, n, p, ph, ox, oy, sb, s;
    logic [15:0] base, ea, a1, a2, a3;
    logic rv, st;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      w  = (k == 0) ? IW0 : IW1;
      n  = (w / 2) * (w / 2);
      sb = (k == 0) ? 32'h0100 : 32'h0000;
      rv = (k == 0) ? rst_n0 : rst_n1;
      st = (k == 0) ? start0 : start1;
      if (!rv) begin
        check($sformatf("reset_outputs%0d", k),
              {busy_s[k], done_s[k], rd_s[k], wr_s[k], addr_s[k], wdata_s[k]}, 32'h0);
        act[k] = 1'b0;
      end else if (act[k]) begin
        cyc[k]++;
        if (cyc[k] <= 6 * n) begin
          p    = (cyc[k] - 1) / 6;
          ph   = (cyc[k] - 1) % 6;
          ox   = p % (w / 2);
          oy   = p / (w / 2);
          base = 16'(sb + 2 * oy * w + 2 * ox);
          check($sformatf("strobes%0d_px%0d_ph%0d", k, p, ph),
                {busy_s[k], done_s[k], rd_s[k], wr_s[k]},
                {1'b1, 1'b0, (ph < 4) ? 1'b1 : 1'b0, (ph == 5) ? 1'b1 : 1'b0});
          if (ph < 4) begin
            ea = 16'(base + (ph / 2) * w + (ph % 2));
            check($sformatf("rd_addr%0d_px%0d", k, p), addr_s[k], ea);
          end
          if (ph == 5) begin
            a1 = 16'(base + 1);
            a2 = 16'(base + w);
            a3 = 16'(base + w + 1);
            s  = int'(src_img[k][base]) + int'(src_img[k][a1])
               + int'(src_img[k][a2]) + int'(src_img[k][a3]);
            check($sformatf("wr_addr%0d_px%0d", k, p), addr_s[k], 16'(16'h4000 + p));
            check($sformatf("wr_data%0d_px%0d", k, p), wdata_s[k], (s + 2) / 4);
          end
        end else begin
          check($sformatf("done_cycle%0d", k),
                {busy_s[k], done_s[k], rd_s[k], wr_s[k]}, 4'b0100);
          act[k] = 1'b0;
        end
      end else begin
        check($sformatf("idle%0d", k), {busy_s[k], done_s[k], rd_s[k], wr_s[k]}, 4'b0000);
        if (st) begin
          act[k] = 1'b1;
          cyc[k] = 0;
        end
      end
    end
  end

  task automatic run_frame(input bit pulses, output int lat, output int dn);
    rd_q.delete();
    wr_q.delete();
    lat = -1;
    dn  = 0;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int i = 0; i < 6 * N0 + 40; i++) begin
      start0 = pulses && (i == 2 || i == 19);
      if (rd_s[0]) rd_q.push_back(addr_s[0]);
      if (wr_s[0]) wr_q.push_back(addr_s[0]);
      if (done_s[0]) begin
        dn++;
        if (lat < 0) lat = i;
      end
      @(posedge clk); #1;
    end
    start0 = 1'b0;
  endtask

  task automatic fill_small_random();
    for (int a = 16'h0100; a < 16'h0140; a++) src_img[0][a] = 8'($urandom);
  endtask

  initial begin
    int lat, dn, lat1, dn1, bad, busy_cnt, wr_seen;
    rst_n0 = 1'b1; rst_n1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
    #1;
    rst_n0 = 1'b0; rst_n1 = 1'b0;
    for (int a = 0; a < 16384; a++) src_img[1][a] = 8'($urandom);
    for (int a = 16'h0100; a < 16'h0140; a++) src_img[0][a] = 8'h80;
    repeat (3) @(posedge clk);
    #1;
    rst_n0 = 1'b1; rst_n1 = 1'b1;
    @(posedge clk); #1;

    fork
      begin
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        lat1 = -1;
        dn1  = 0;
        for (int i = 0; i < 6 * N1 + 20; i++) begin
          if (done_s[1]) begin
            dn1++;
            if (lat1 < 0) lat1 = i;
          end
          @(posedge clk); #1;
        end
        check("full_frame_latency", lat1, 6 * N1);
        check("full_frame_done_count", dn1, 1);
      end
      begin
        // uniform image
        run_frame(1'b0, lat, dn);
        check("uniform_done_latency", lat, 96);
        check("uniform_done_count", dn, 1);
        check("uniform_write_count", wr_q.size(), 16);
        bad = 0;
        for (int a = 0; a < 16; a++) if (dst_mem[0][16'h4000 + a] !== 8'h80) bad++;
        check("uniform_bad_bytes", bad, 0);

        // rounding blocks and address order, with ignored start pulses
        fill_small_random();
        src_img[0][16'h0100] = 8'd1;   src_img[0][16'h0101] = 8'd2;
        src_img[0][16'h0108] = 8'd2;   src_img[0][16'h0109] = 8'd2;
        src_img[0][16'h0102] = 8'd255; src_img[0][16'h0103] = 8'd255;
        src_img[0][16'h010A] = 8'd255; src_img[0][16'h010B] = 8'd255;
        src_img[0][16'h0104] = 8'd0;   src_img[0][16'h0105] = 8'd0;
        src_img[0][16'h010C] = 8'd0;   src_img[0][16'h010D] = 8'd1;
        src_img[0][16'h0106] = 8'd0;   src_img[0][16'h0107] = 8'd0;
        src_img[0][16'h010E] = 8'd1;   src_img[0][16'h010F] = 8'd1;
        run_frame(1'b1, lat, dn);
        check("ignored_start_done_count", dn, 1);
        check("round_sum7", dst_mem[0][16'h4000], 8'd2);
        check("round_all255", dst_mem[0][16'h4001], 8'd255);
        check("round_sum1", dst_mem[0][16'h4002], 8'd0);
        check("round_sum2", dst_mem[0][16'h4003], 8'd1);
        check("read_count", rd_q.size(), 64);
        if (rd_q.size() == 64) begin
          check("px11_rd0", rd_q[20], 16'h0112);
          check("px11_rd1", rd_q[21], 16'h0113);
          check("px11_rd2", rd_q[22], 16'h011A);
          check("px11_rd3", rd_q[23], 16'h011B);
        end
        if (wr_q.size() == 16) check("px11_wr_addr", wr_q[5], 16'h4005);

        // start held high: back-to-back frames
        fill_small_random();
        busy_cnt = 0;
        dn = 0;
        start0 = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 3 * (6 * N0 + 2) - 1; i++) begin
          #1;
          if (busy_s[0]) busy_cnt++;
          if (done_s[0]) dn++;
          @(posedge clk);
        end
        #1;
        start0 = 1'b0;
        check("held_start_done_count", dn, 3);
        check("held_start_busy_cycles", busy_cnt, 3 * 6 * N0);
        repeat (4) @(posedge clk);
        #1;

        // reset in pixel 10, RD2
        fill_small_random();
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (62) @(posedge clk);
        #1;
        check("reset_point_strobe", {rd_s[0], wr_s[0]}, 2'b10);
        check("reset_point_addr", addr_s[0], 16'h012C);
        rst_n0 = 1'b0;
        #1;
        check("async_reset_outputs",
              {busy_s[0], done_s[0], rd_s[0], wr_s[0], addr_s[0], wdata_s[0]}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n0 = 1'b1;
        wr_seen = 0;
        repeat (10) begin
          @(posedge clk); #1;
          if (wr_s[0] || busy_s[0]) wr_seen++;
        end
        check("no_activity_after_reset", wr_seen, 0);
        fill_small_random();
        run_frame(1'b0, lat, dn);
        check("restart_done_latency", lat, 96);
        check("restart_done_count", dn, 1);
        if (rd_q.size() > 0) check("restart_first_addr", rd_q[0], 16'h0100);
        else check("restart_read_count", rd_q.size(), 64);
      end
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
